// File: rtl/pcg_arbiter.sv
// Round-robin arbiter that hands out PCG32 (XSH-RR) numbers, one per grant.
// Each grant takes three cycles: IDLE picks a winner, STEP advances the LCG, OUT presents the number.
module pcg_arbiter #(
  parameter logic [63:0] MULT = 64'h5851F42D4C957F2D,
  parameter logic [63:0] INC  = 64'h14057B7EF767814F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic        seed_we,
  input  logic [7:0]  seed_in,
  output logic [3:0]  gnt,
  output logic        data_valid,
  output logic [31:0] data_out,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StStep = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_s;
  logic [1:0]  r_p;
  logic [1:0]  r_w;
  logic [31:0] r_data;

  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_found;
  logic [31:0] w_x;
  logic [4:0]  w_rot;
  logic [31:0] w_perm;

  // The search starts at the pointer, so the most recent winner is considered last.
  always_comb begin
    w_win   = r_p;
    w_idx   = r_p;
    w_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_p + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // When the rotate amount is zero, the left shift is by 32 and contributes nothing.
  always_comb begin
    w_x    = 32'((r_s ^ (r_s >> 18)) >> 27);
    w_rot  = r_s[63:59];
    w_perm = (w_x >> w_rot) | (w_x << (6'd32 - {1'b0, w_rot}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_s     <= 64'd0;
      r_p     <= 2'd0;
      r_w     <= 2'd0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (seed_we) begin
            r_s <= {r_s[55:0], seed_in};
          end else if (|req) begin
            r_w     <= w_win;
            r_state <= StStep;
          end
        end
        StStep: begin
          r_data  <= w_perm;
          r_s     <= r_s * MULT + INC;
          r_state <= StOut;
        end
        StOut: begin
          r_p     <= r_w + 2'd1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    data_valid = (r_state == StOut);
    gnt        = data_valid ? (4'b0001 << r_w) : 4'b0000;
    busy       = (r_state != StIdle);
    data_out   = r_data;
  end

endmodule

// File: tb/tb_pcg_arbiter.sv
// Directed bench for pcg_arbiter, ending with a short random run against a cycle model.
module tb_pcg_arbiter;

  localparam logic [63:0] MULT_T = 64'h5851F42D4C957F2D;
  localparam logic [63:0] INC_T  = 64'h14057B7EF767814F;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic        seed_we;
  logic [7:0]  seed_in;
  logic [3:0]  gnt;
  logic        data_valid;
  logic [31:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_s;
  logic [1:0]  m_st;
  logic [1:0]  m_p;
  logic [1:0]  m_w;
  logic [31:0] m_data;
  logic        m_found;
  logic [1:0]  m_idx;

  pcg_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .seed_we    (seed_we),
    .seed_in    (seed_in),
    .gnt        (gnt),
    .data_valid (data_valid),
    .data_out   (data_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden permute: rotate one bit at a time.
  function automatic logic [31:0] permute_m(input logic [63:0] s);
    logic [63:0] t;
    logic [31:0] x;
    int          r;
    t = (s ^ (s >> 18)) >> 27;
    x = t[31:0];
    r = int'(s[63:59]);
    for (int i = 0; i < r; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full grant from IDLE with req already applied.
  task automatic do_grant(input string tag, input logic [3:0] exp_gnt, input logic [31:0] exp_data);
    tick();
    chk({tag, "_step_busy"}, 64'(busy), 64'd1);
    chk({tag, "_step_dv"}, 64'(data_valid), 64'd0);
    chk({tag, "_step_gnt"}, 64'(gnt), 64'd0);
    tick();
    chk({tag, "_out_dv"}, 64'(data_valid), 64'd1);
    chk({tag, "_out_gnt"}, 64'(gnt), 64'(exp_gnt));
    chk({tag, "_out_data"}, 64'(data_out), 64'(exp_data));
    tick();
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_data_hold"}, 64'(data_out), 64'(exp_data));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_s = 64'd0;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    seed_we = 1'b0;
    seed_in = 8'h00;
    #12;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_s = 64'd0;

    // Single requester from reset: first number is permute(0), then permute(INC).
    req = 4'b0001;
    do_grant("r0_g0", 4'b0001, 32'h0000_0000);
    chk("r0_s_after", dut.r_s, INC_T);
    m_s = INC_T;
    do_grant("r0_g1", 4'b0001, permute_m(m_s));
    m_s = m_s * MULT_T + INC_T;
    req = 4'b0000;

    // All four requesting: strict rotation from pointer 0.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      do_grant("rr", 4'b0001 << (k % 4), permute_m(m_s));
      m_s = m_s * MULT_T + INC_T;
    end
    req = 4'b0000;

    // Seed bytes 01..08.
    for (int b = 1; b <= 8; b++) begin
      seed_we = 1'b1;
      seed_in = 8'(b);
      tick();
    end
    seed_we = 1'b0;
    chk("seed_s", dut.r_s, 64'h0102_0304_0506_0708);
    chk("seed_busy", 64'(busy), 64'd0);
    m_s = 64'h0102_0304_0506_0708;
    req = 4'b0001;
    do_grant("seed_g", 4'b0001, permute_m(m_s));
    m_s = m_s * MULT_T + INC_T;
    req = 4'b0000;

    // Requester 2 drops req during STEP; a seed write in STEP is ignored.
    req = 4'b0100;
    tick();
    req     = 4'b0000;
    seed_we = 1'b1;
    seed_in = 8'hAA;
    tick();
    seed_we = 1'b0;
    chk("drop_gnt", 64'(gnt), 64'(4'b0100));
    chk("drop_dv", 64'(data_valid), 64'd1);
    chk("drop_data", 64'(data_out), 64'(permute_m(m_s)));
    m_s = m_s * MULT_T + INC_T;
    chk("drop_s", dut.r_s, m_s);
    tick();
    chk("drop_p", 64'(dut.r_p), 64'd3);
    chk("drop_s_idle", dut.r_s, m_s);
    chk("drop_idle_busy", 64'(busy), 64'd0);

    // Reset in OUT drops outputs without a clock edge.
    req = 4'b0010;
    tick();
    tick();
    chk("abort_pre_dv", 64'(data_valid), 64'd1);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt", 64'(gnt), 64'd0);
    chk("abort_dv", 64'(data_valid), 64'd0);
    chk("abort_data", 64'(data_out), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("abort_s", dut.r_s, 64'd0);
    chk("abort_p", 64'(dut.r_p), 64'd0);
    chk("abort_busy_rel", 64'(busy), 64'd0);
    tick();
    chk("abort_no_grant", 64'(data_valid), 64'd0);

    // Random stimulus against a cycle model, starting from the reset state.
    m_st = 2'd0; m_s = 64'd0; m_p = 2'd0; m_w = 2'd0; m_data = 32'd0;
    for (int c = 0; c < 400; c++) begin
      req     = 4'($urandom_range(0, 15));
      seed_we = ($urandom_range(0, 3) == 0);
      seed_in = 8'($urandom_range(0, 255));
      @(posedge clk);
      case (m_st)
        2'd0: begin
          if (seed_we) begin
            m_s = {m_s[55:0], seed_in};
          end else if (req != 4'b0000) begin
            m_found = 1'b0;
            for (int i = 0; i < 4; i++) begin
              m_idx = m_p + 2'(i);
              if (!m_found && req[m_idx]) begin
                m_w     = m_idx;
                m_found = 1'b1;
              end
            end
            m_st = 2'd1;
          end
        end
        2'd1: begin
          m_data = permute_m(m_s);
          m_s    = m_s * MULT_T + INC_T;
          m_st   = 2'd2;
        end
        default: begin
          m_p  = m_w + 2'd1;
          m_st = 2'd0;
        end
      endcase
      #1;
      chk("rnd_dv", 64'(data_valid), 64'(m_st == 2'd2));
      chk("rnd_gnt", 64'(gnt), 64'((m_st == 2'd2) ? (4'b0001 << m_w) : 4'b0000));
      chk("rnd_busy", 64'(busy), 64'(m_st != 2'd0));
      chk("rnd_data", 64'(data_out), 64'(m_data));
    end
    chk("rnd_s_final", dut.r_s, m_s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
